// File: rtl/ssd_marquee.sv
// ssd_marquee: scrolling-text engine for a multiplexed 7-segment display.
// Holds a runtime-writable ring of DEPTH segment patterns. A DIGITS-wide
// window scrolls across the ring once every SCROLL_DIV enabled cycles, in
// either direction. The window is scanned onto a shared segment bus with one
// digit slot of SCAN_DIV cycles each.
//
// Ports:
//   clk      board clock, all state on the rising edge
//   rst_n    synchronous active-low reset
//   en       1 = scrolling enabled, 0 = window frozen (scan keeps running)
//   dir      0 = scroll left (head increments), 1 = scroll right (decrements)
//   wr_en    ring write strobe
//   wr_addr  absolute ring index to write (indices >= DEPTH are ignored)
//   wr_data  active-low segment pattern, bit7..bit0 = a,b,c,d,e,f,g,dp
//   BCD_dsp  registered active-low segment bus
//   bit_dsp  registered active-low one-cold digit enables
//   head     ring index shown on the leftmost digit
module ssd_marquee #(
  parameter int unsigned DEPTH      = 6,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCROLL_DIV = 25_000_000,
  parameter int unsigned SCAN_DIV   = 50_000,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dir,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        BCD_dsp,
  output logic [DIGITS-1:0] bit_dsp,
  output logic [AW-1:0]     head
);

  localparam int unsigned SW = $clog2(SCROLL_DIV);
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [SW-1:0]     sc_q, sc_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [DW-1:0]     d_q, d_d;
  logic [7:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0] bit_q, bit_d;

  logic              tick;
  logic              scan_tc;
  int unsigned       win_sum;
  logic [AW-1:0]     win_idx;

  assign tick    = en && (sc_q == SW'(SCROLL_DIV - 1));
  assign scan_tc = (pc_q == PW'(SCAN_DIV - 1));

  // Ring write; out-of-range addresses are dropped.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Scroll counter freezes (keeps its value) while en is low.
  always_comb begin
    sc_d   = sc_q;
    head_d = head_q;
    if (en) begin
      sc_d = tick ? '0 : sc_q + SW'(1);
    end
    if (tick) begin
      if (dir) begin
        head_d = (head_q == '0) ? AW'(DEPTH - 1) : head_q - AW'(1);
      end else begin
        head_d = (head_q == AW'(DEPTH - 1)) ? '0 : head_q + AW'(1);
      end
    end
  end

  // Digit scan walks from the leftmost digit (DIGITS-1) down to 0.
  always_comb begin
    pc_d = scan_tc ? '0 : pc_q + PW'(1);
    d_d  = d_q;
    if (scan_tc) begin
      d_d = (d_q == '0) ? DW'(DIGITS - 1) : d_q - DW'(1);
    end
  end

  // Digit d shows ring entry (head + DIGITS-1-d) mod DEPTH; exact modulo so a
  // ring shorter than the display simply repeats.
  always_comb begin
    win_sum = 32'(head_q) + (DIGITS - 1) - 32'(d_q);
    win_idx = AW'(win_sum % DEPTH);
    bcd_d   = mem_q[win_idx];
    bit_d   = ~(DIGITS'(1) << d_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'hFF;
      end
      head_q <= '0;
      sc_q   <= '0;
      pc_q   <= '0;
      d_q    <= DW'(DIGITS - 1);
      bcd_q  <= 8'hFF;
      bit_q  <= '1;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      sc_q   <= sc_d;
      pc_q   <= pc_d;
      d_q    <= d_d;
      bcd_q  <= bcd_d;
      bit_q  <= bit_d;
    end
  end

  assign BCD_dsp = bcd_q;
  assign bit_dsp = bit_q;
  assign head    = head_q;

endmodule

// File: doc/ssd_marquee.md
# ssd_marquee

Parametrised scrolling-text engine for the multiplexed 7-segment display. It holds a ring of DEPTH segment patterns, scrolls a DIGITS-wide window across the ring at a programmable rate in either direction, and scans the window onto the shared segment bus. The ring is runtime-writable. It replaces the fixed six-letter, left-only scroller plus separate frequency divider and display controller with one block driven directly from the board clock.

## Interface
- DEPTH, 6, number of characters in the ring (2..64)
- DIGITS, 4, number of physical digits (1..8)
- SCROLL_DIV, 25_000_000, clk cycles per scroll step (>=2)
- SCAN_DIV, 50_000, clk cycles per digit scan slot (>=1)
- AW, $clog2(DEPTH), ring address width (derived, not overridden)

Ports:
- clk  in  1  board clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  1 = scrolling enabled; 0 = window frozen (scan continues)
- dir  in  1  0 = scroll left (head increments), 1 = scroll right (head decrements)
- wr_en  in  1  ring write strobe, one write per cycle
- wr_addr  in  AW  absolute ring index to write
- wr_data  in  8  segment pattern, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp
- BCD_dsp  out  8  segment bus, active-low, registered
- bit_dsp  out  DIGITS  digit enables, active-low one-cold, registered
- head  out  AW  ring index shown on the leftmost digit

## Operation
- Ring mem[0..DEPTH-1], 8 bits each. Reset fills every entry with 8'hFF (blank).
- Write: wr_en=1 and wr_addr<DEPTH loads mem[wr_addr] at the next edge. wr_addr>=DEPTH is ignored.
- Scroll counter sc runs 0..SCROLL_DIV-1 while en=1. It is frozen (not cleared) while en=0.
- A tick occurs when en=1 and sc==SCROLL_DIV-1. On a tick, sc returns to 0 and head steps once.
- Step with dir=0: head+1, with DEPTH-1 wrapping to 0. Step with dir=1: head-1, with 0 wrapping to DEPTH-1.
- dir is sampled only at the tick. A dir change mid-interval takes effect at the next tick.
- Window mapping: physical digit k (k=DIGITS-1 is leftmost) shows mem[(head + DIGITS-1-k) mod DEPTH]. The modulo is exact for any DEPTH, including DEPTH<DIGITS, where the characters repeat.
- Scan counter pc runs 0..SCAN_DIV-1. At its terminal count, digit index d steps DIGITS-1 down to 0, then wraps back to DIGITS-1. Scanning ignores en.
- Output register each cycle: bit_dsp = ~(1<<d), BCD_dsp = window pattern for digit d.
- Simultaneous write and tick: both occur. The write lands at its absolute address regardless of the head move.
- Write to the entry currently displayed: the new pattern appears on BCD_dsp one cycle after the write edge, during that digit's slot.

## Timing
- Reset (rst_n=0 at an edge): head=0, sc=0, pc=0, d=DIGITS-1, BCD_dsp=8'hFF, bit_dsp=all ones, all mem=8'hFF.
- First edge with rst_n=1: outputs show digit DIGITS-1 (bit_dsp=~(1<<(DIGITS-1)), BCD_dsp=8'hFF).
- Reset asserted mid-operation overrides all other activity in that cycle, including any tick or write.
- Tick latency: head changes on the tick edge. BCD_dsp reflects the new head one edge later.
- Scroll period is exactly SCROLL_DIV cycles of en=1. Cycles with en=0 do not count.
- Each digit stays on for exactly SCAN_DIV cycles. A full refresh takes DIGITS*SCAN_DIV cycles.
- Write-to-display latency is one edge after the write edge, plus the wait until that digit's scan slot.

## Test plan
Bench parameters: DEPTH=6, DIGITS=4, SCROLL_DIV=4, SCAN_DIV=2.

- Reset, then write mem[0..5] = D5,E1,91,83,61,61 ("NTHUEE") -> head=0; over 8 cycles BCD_dsp shows D5,E1,91,83 with bit_dsp = 0111,1011,1101,1110.
- en=1, dir=0 for 24 cycles -> head visits 1,2,3,4,5,0, one step every 4 cycles. At head=4 the window is 61,61,D5,E1 (wrap-around).
- From head=0, dir=1 -> next head=5, window 61,D5,E1,91. Toggle dir two cycles before a tick -> the new direction applies at that tick.
- en=0 for 10 cycles with sc=2, then en=1 -> head holds; the next tick occurs exactly 2 cycles after re-enable. bit_dsp keeps scanning throughout.
- Write mem[(head+1)%6]=8'h03 on a tick edge, plus wr_addr=7 with 8'h00 -> head steps and the entry updates together; the address-7 write leaves all entries unchanged.
- Pulse rst_n=0 for one edge mid-scroll, with wr_en=1 -> head=0, all entries 8'hFF, BCD_dsp=8'hFF, bit_dsp=1111; the write is dropped.
